// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// occupancy state encodings and the RV32 NOP used as the bubble value.
package pipe_stage_reg_pkg;

  // Occupancy of the register: nothing held, main entry held, main + skid held.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } ps_state_e;

  // ADDI x0, x0, 0 -- the canonical RV32 NOP, injected as a pipeline bubble.
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for pipeline statistics. It counts one per
// cycle with INC high and sticks at all-ones instead of wrapping.
module pipe_stage_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             INC,
  output logic [WIDTH-1:0] COUNT
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: increment only while below the saturation value.
  always_comb begin
    count_d = count_q;
    if (INC && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign COUNT = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic multi-lane inter-stage pipeline register with valid/ready
// handshake, a one-entry skid buffer behind the main entry, a synchronous
// FLUSH that turns the stage into a bubble, and the global BUSYWAIT freeze.
// Optional statistics counters are built when PIPE_STAGE_REG_STATS_EN is
// defined; without it the ports and counters do not exist.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    NUM_LANES    = 2,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = DATA_WIDTH'(RV32_NOP)
`ifdef PIPE_STAGE_REG_STATS_EN
  ,
  parameter int                    CNT_WIDTH    = 16
`endif
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            BUSYWAIT,
  input  logic                            FLUSH,
  input  logic                            IN_VALID,
  output logic                            IN_READY,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] IN_DATA,
  output logic                            OUT_VALID,
  input  logic                            OUT_READY,
  output logic [NUM_LANES*DATA_WIDTH-1:0] OUT_DATA
`ifdef PIPE_STAGE_REG_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]            STALL_CYCLES,
  output logic [CNT_WIDTH-1:0]            BUBBLE_CYCLES
`endif
);

  localparam int W = NUM_LANES * DATA_WIDTH;
  // Lane 0 carries the bubble value, every other lane is zero.
  localparam logic [W-1:0] BUBBLE_WORD = W'(BUBBLE_VALUE);

  ps_state_e      state_q, state_d;
  logic [W-1:0]   main_q,  main_d;
  logic [W-1:0]   skid_q,  skid_d;
  logic           push;
  logic           pop;

  // Handshake qualifiers; BUSYWAIT blocks both sides of the transfer.
  always_comb begin
    IN_READY = (state_q != PS_SKID) && !BUSYWAIT;
    push     = IN_VALID && IN_READY;
    pop      = OUT_VALID && OUT_READY && !BUSYWAIT;
  end

  // Next state and data; FLUSH wins over everything but reset and drops any push.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (FLUSH) begin
      state_d                  = PS_EMPTY;
      main_d[DATA_WIDTH-1:0]   = BUBBLE_VALUE;
      skid_d[DATA_WIDTH-1:0]   = BUBBLE_VALUE;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (push) begin
            state_d = PS_FULL;
            main_d  = IN_DATA;
          end
        end
        PS_FULL: begin
          if (push && pop) begin
            main_d = IN_DATA;
          end else if (push) begin
            state_d = PS_SKID;
            skid_d  = IN_DATA;
          end else if (pop) begin
            state_d = PS_EMPTY;
          end
        end
        PS_SKID: begin
          // IN_READY is low here, so only draining is possible.
          if (pop) begin
            state_d = PS_FULL;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = PS_EMPTY;
        end
      endcase
    end
  end

  // State and entry registers; reset discards held data and loads bubbles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= PS_EMPTY;
      main_q  <= BUBBLE_WORD;
      skid_q  <= BUBBLE_WORD;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign OUT_VALID = (state_q != PS_EMPTY);
  assign OUT_DATA  = main_q;

`ifdef PIPE_STAGE_REG_STATS_EN
  pipe_stage_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (BUSYWAIT),
    .COUNT (STALL_CYCLES)
  );

  pipe_stage_sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (!OUT_VALID),
    .COUNT (BUBBLE_CYCLES)
  );
`endif

endmodule
